// File: rtl/scsi_io_arbiter.sv
// scsi_io_arbiter: round-robin sharing of one host sector channel between two SCSI targets.
// Define SCSI_ARB_WATCHDOG_EN to add the transfer watchdog and its sticky timeout_flag output.
module scsi_io_arbiter #(
  parameter int TIMEOUT_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] t_lba0,
  input  logic [31:0] t_lba1,
  input  logic [1:0]  t_rd,
  input  logic [1:0]  t_wr,
  output logic [1:0]  t_ack,
  input  logic [7:0]  t_buff_din0,
  input  logic [7:0]  t_buff_din1,
  output logic [1:0]  t_buff_wr,
  output logic [8:0]  buff_addr,
  output logic [7:0]  buff_dout,
  output logic [31:0] h_lba,
  output logic        h_dev,
  output logic        h_rd,
  output logic        h_wr,
  input  logic        h_ack,
  input  logic [8:0]  h_buff_addr,
  input  logic [7:0]  h_buff_dout,
  input  logic        h_buff_wr,
  output logic [7:0]  h_buff_din,
`ifdef SCSI_ARB_WATCHDOG_EN
  output logic        timeout_flag,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  if (TIMEOUT_W < 2) begin : g_timeout_w_check
    $error("scsi_io_arbiter: TIMEOUT_W must be at least 2");
  end

  state_t      state, state_n;
  logic [31:0] h_lba_n;
  logic        h_dev_n;
  logic        h_rd_n, h_wr_n;
  logic [1:0]  t_ack_n;
  logic        op, op_n;
  logic        last_grant, last_grant_n;
  logic [1:0]  req;
  logic        grant;
  logic [1:0]  owner;

`ifdef SCSI_ARB_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] watchdog, watchdog_n;
  logic                 timeout_flag_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      h_lba      <= '0;
      h_dev      <= 1'b0;
      h_rd       <= 1'b0;
      h_wr       <= 1'b0;
      t_ack      <= '0;
      op         <= 1'b0;
      last_grant <= 1'b1;
`ifdef SCSI_ARB_WATCHDOG_EN
      watchdog     <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      h_lba      <= h_lba_n;
      h_dev      <= h_dev_n;
      h_rd       <= h_rd_n;
      h_wr       <= h_wr_n;
      t_ack      <= t_ack_n;
      op         <= op_n;
      last_grant <= last_grant_n;
`ifdef SCSI_ARB_WATCHDOG_EN
      watchdog     <= watchdog_n;
      timeout_flag <= timeout_flag_n;
`endif
    end
  end

  // Both requesting: hand the channel to whoever did not have it last.
  always_comb begin
    req   = t_rd | t_wr;
    grant = (req == 2'b11) ? ~last_grant : req[1];
    owner = h_dev ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_n      = state;
    h_lba_n      = h_lba;
    h_dev_n      = h_dev;
    h_rd_n       = 1'b0;
    h_wr_n       = 1'b0;
    t_ack_n      = '0;
    op_n         = op;
    last_grant_n = last_grant;
`ifdef SCSI_ARB_WATCHDOG_EN
    watchdog_n     = watchdog;
    timeout_flag_n = timeout_flag;
`endif

    case (state)
      IDLE: begin
        if (|req) begin
          h_dev_n      = grant;
          h_lba_n      = grant ? t_lba1 : t_lba0;
          op_n         = grant ? t_wr[1] : t_wr[0];
          last_grant_n = grant;
          state_n      = REQ;
`ifdef SCSI_ARB_WATCHDOG_EN
          watchdog_n   = '0;
`endif
        end
      end
      REQ: begin
        if (h_ack) begin
          t_ack_n = owner;
          state_n = XFER;
        end else begin
          h_rd_n = ~op;
          h_wr_n = op;
        end
      end
      XFER: begin
        if (h_ack) begin
          t_ack_n = owner;
        end else begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

`ifdef SCSI_ARB_WATCHDOG_EN
    // Expiry overrides the normal REQ/XFER outcome: one ack pulse unblocks the target.
    if (state == REQ || state == XFER) begin
      watchdog_n = watchdog + 1'b1;
      if (watchdog == '1) begin
        h_rd_n         = 1'b0;
        h_wr_n         = 1'b0;
        t_ack_n        = owner;
        timeout_flag_n = 1'b1;
        state_n        = DONE;
      end
    end
`endif
  end

  always_comb begin
    busy       = (state != IDLE);
    buff_addr  = h_buff_addr;
    buff_dout  = h_buff_dout;
    t_buff_wr  = '0;
    h_buff_din = '0;
    if (state == XFER) begin
      t_buff_wr  = h_buff_wr ? owner : 2'b00;
      h_buff_din = h_dev ? t_buff_din1 : t_buff_din0;
    end
  end

endmodule

// File: tb/tb_scsi_io_arbiter.sv
// Directed self-checking bench for scsi_io_arbiter (watchdog checks run when SCSI_ARB_WATCHDOG_EN is defined).
module tb_scsi_io_arbiter;

  localparam int TW = 10;

  logic        clk;
  logic        rst_n;
  logic [31:0] t_lba0, t_lba1;
  logic [1:0]  t_rd, t_wr;
  logic [1:0]  t_ack;
  logic [7:0]  t_buff_din0, t_buff_din1;
  logic [1:0]  t_buff_wr;
  logic [8:0]  buff_addr;
  logic [7:0]  buff_dout;
  logic [31:0] h_lba;
  logic        h_dev, h_rd, h_wr, h_ack;
  logic [8:0]  h_buff_addr;
  logic [7:0]  h_buff_dout;
  logic        h_buff_wr;
  logic [7:0]  h_buff_din;
  logic        busy;
`ifdef SCSI_ARB_WATCHDOG_EN
  logic        timeout_flag;
`endif

  int checks = 0;
  int errors = 0;

  scsi_io_arbiter #(.TIMEOUT_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .t_lba0      (t_lba0),
    .t_lba1      (t_lba1),
    .t_rd        (t_rd),
    .t_wr        (t_wr),
    .t_ack       (t_ack),
    .t_buff_din0 (t_buff_din0),
    .t_buff_din1 (t_buff_din1),
    .t_buff_wr   (t_buff_wr),
    .buff_addr   (buff_addr),
    .buff_dout   (buff_dout),
    .h_lba       (h_lba),
    .h_dev       (h_dev),
    .h_rd        (h_rd),
    .h_wr        (h_wr),
    .h_ack       (h_ack),
    .h_buff_addr (h_buff_addr),
    .h_buff_dout (h_buff_dout),
    .h_buff_wr   (h_buff_wr),
    .h_buff_din  (h_buff_din),
`ifdef SCSI_ARB_WATCHDOG_EN
    .timeout_flag(timeout_flag),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_host_req(input string tag);
    int n;
    n = 0;
    while (!(h_rd || h_wr) && n < 10) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, h_rd | h_wr}, 32'd1);
  endtask

  // One host service with request level held by the targets; t_ack must be one-hot on the owner.
  task automatic serve(input logic exp_dev, input logic [31:0] exp_lba, input string tag);
    logic bad;
    bad = 1'b0;
    wait_host_req({tag, "_req"});
    chk({tag, "_dev"}, {31'd0, h_dev}, {31'd0, exp_dev});
    chk({tag, "_lba"}, h_lba, exp_lba);
    h_ack = 1'b1;
    repeat (4) begin
      tick();
      if (t_ack !== (exp_dev ? 2'b10 : 2'b01)) bad = 1'b1;
    end
    chk({tag, "_ack"}, {31'd0, bad}, 32'd0);
    h_ack = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; t_lba0 = '0; t_lba1 = '0; t_rd = '0; t_wr = '0;
    t_buff_din0 = '0; t_buff_din1 = '0; h_ack = 1'b0;
    h_buff_addr = '0; h_buff_dout = '0; h_buff_wr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_h_rd", {31'd0, h_rd}, 32'd0);
    chk("rst_h_wr", {31'd0, h_wr}, 32'd0);
    chk("rst_t_ack", {30'd0, t_ack}, 32'd0);
    chk("rst_h_dev", {31'd0, h_dev}, 32'd0);
    chk("rst_h_lba", h_lba, 32'd0);
    chk("rst_h_buff_din", {24'd0, h_buff_din}, 32'd0);
`ifdef SCSI_ARB_WATCHDOG_EN
    chk("rst_timeout_flag", {31'd0, timeout_flag}, 32'd0);
`endif

    // Single read from target 0
    t_lba0 = 32'h0000_1234; t_buff_din0 = 8'h77; t_rd = 2'b01;
    tick();
    chk("rd_busy_after_grant", {31'd0, busy}, 32'd1);
    chk("rd_h_rd_not_yet", {31'd0, h_rd}, 32'd0);
    tick();
    chk("rd_h_rd_2clk", {31'd0, h_rd}, 32'd1);
    chk("rd_h_wr", {31'd0, h_wr}, 32'd0);
    chk("rd_h_dev", {31'd0, h_dev}, 32'd0);
    chk("rd_h_lba", h_lba, 32'h0000_1234);
    chk("rd_buff_wr_outside_xfer", {30'd0, t_buff_wr}, 32'd0);
    tick();
    h_ack = 1'b1;
    tick();
    chk("rd_h_rd_drop_on_ack", {31'd0, h_rd}, 32'd0);
    chk("rd_t_ack_set", {30'd0, t_ack}, 32'd1);
    t_rd = 2'b00;
    #1;
    chk("rd_h_buff_din", {24'd0, h_buff_din}, 32'h77);
    cnt = 0;
    for (int i = 0; i < 599; i++) begin
      tick();
      if (t_ack === 2'b01) cnt++;
      if (i == 10) begin
        h_buff_addr = 9'd5; h_buff_dout = 8'hA5; h_buff_wr = 1'b1;
        #1;
        chk("rd_t_buff_wr", {30'd0, t_buff_wr}, 32'd1);
        chk("rd_buff_dout", {24'd0, buff_dout}, 32'hA5);
        chk("rd_buff_addr", {23'd0, buff_addr}, 32'd5);
      end
      if (i == 11) h_buff_wr = 1'b0;
    end
    chk("rd_t_ack_held_cycles", cnt, 32'd599);
    h_ack = 1'b0;
    tick();
    chk("rd_t_ack_fall", {30'd0, t_ack}, 32'd0);
    chk("rd_done_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("rd_idle_busy", {31'd0, busy}, 32'd0);

    // Write path from target 1
    t_lba1 = 32'hCAFE_0001; t_buff_din1 = 8'h3C; t_wr = 2'b10;
    tick();
    tick();
    chk("wr_h_wr", {31'd0, h_wr}, 32'd1);
    chk("wr_h_rd", {31'd0, h_rd}, 32'd0);
    chk("wr_h_dev", {31'd0, h_dev}, 32'd1);
    chk("wr_h_lba", h_lba, 32'hCAFE_0001);
    h_ack = 1'b1;
    tick();
    t_wr = 2'b00;
    chk("wr_t_ack", {30'd0, t_ack}, 32'd2);
    chk("wr_h_buff_din", {24'd0, h_buff_din}, 32'h3C);
    chk("wr_t_buff_wr_idle", {30'd0, t_buff_wr}, 32'd0);
    tick();
    h_ack = 1'b0;
    tick();
    tick();
    chk("wr_h_buff_din_after", {24'd0, h_buff_din}, 32'd0);

    // Contention: both request continuously
    t_lba0 = 32'hAAAA_0000; t_lba1 = 32'hBBBB_1111; t_rd = 2'b11;
    serve(1'b0, 32'hAAAA_0000, "cont0");
    serve(1'b1, 32'hBBBB_1111, "cont1");
    serve(1'b0, 32'hAAAA_0000, "cont2");
    serve(1'b1, 32'hBBBB_1111, "cont3");
    t_rd = 2'b00;
    tick();
    tick();
    tick();
    chk("cont_idle", {31'd0, busy}, 32'd0);

    // Late arrival: target 1 requests while target 0 owns the channel
    t_lba0 = 32'h0000_0A00; t_lba1 = 32'h0000_0B11; t_rd = 2'b01;
    wait_host_req("late_req0");
    h_ack = 1'b1;
    tick();
    t_rd = 2'b10;
    t_lba0 = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("late_h_dev_xfer", {31'd0, h_dev}, 32'd0);
    chk("late_h_lba_xfer", h_lba, 32'h0000_0A00);
    chk("late_t_ack_xfer", {30'd0, t_ack}, 32'd1);
    h_ack = 1'b0;
    tick();
    chk("late_done_dev", {31'd0, h_dev}, 32'd0);
    chk("late_done_lba", h_lba, 32'h0000_0A00);
    chk("late_done_t_ack", {30'd0, t_ack}, 32'd0);
    tick();
    chk("late_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("late_grant_dev", {31'd0, h_dev}, 32'd1);
    chk("late_grant_lba", h_lba, 32'h0000_0B11);
    tick();
    chk("late_h_rd", {31'd0, h_rd}, 32'd1);

    // Reset mid-XFER
    h_ack = 1'b1;
    tick();
    chk("rstx_t_ack_before", {30'd0, t_ack}, 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; h_ack = 1'b0; t_rd = 2'b00;
    chk("rstx_h_rd", {31'd0, h_rd}, 32'd0);
    chk("rstx_h_wr", {31'd0, h_wr}, 32'd0);
    chk("rstx_t_ack", {30'd0, t_ack}, 32'd0);
    chk("rstx_busy", {31'd0, busy}, 32'd0);
    t_rd = 2'b11;
    tick();
    chk("rstx_fresh_dev", {31'd0, h_dev}, 32'd0);
    chk("rstx_fresh_busy", {31'd0, busy}, 32'd1);

    // Owner drops its request during REQ: host cycle still completes
    t_rd = 2'b10;
    tick();
    chk("drop_h_rd_kept", {31'd0, h_rd}, 32'd1);
    chk("drop_h_dev", {31'd0, h_dev}, 32'd0);
    tick();
    chk("drop_h_rd_still", {31'd0, h_rd}, 32'd1);
    t_rd = 2'b00;
    h_ack = 1'b1;
    tick();
    chk("drop_t_ack", {30'd0, t_ack}, 32'd1);
    h_ack = 1'b0;
    tick();
    tick();
    chk("drop_idle", {31'd0, busy}, 32'd0);

`ifdef SCSI_ARB_WATCHDOG_EN
    // Watchdog: host never acks
    t_rd = 2'b01;
    tick();
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (h_rd) cnt++;
      else break;
    end
    chk("wd_req_cycles", cnt, (32'd1 << TW) - 32'd1);
    chk("wd_h_rd_drop", {31'd0, h_rd}, 32'd0);
    chk("wd_t_ack_pulse", {30'd0, t_ack}, 32'd1);
    chk("wd_flag", {31'd0, timeout_flag}, 32'd1);
    t_rd = 2'b00;
    tick();
    chk("wd_t_ack_end", {30'd0, t_ack}, 32'd0);
    tick();
    chk("wd_flag_sticky", {31'd0, timeout_flag}, 32'd1);
    chk("wd_idle", {31'd0, busy}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scsi_io_arbiter.md
Name: scsi_io_arbiter

Overview:
- Shares one io-controller sector channel (LBA, read/write request, ack, 512-byte buffer port) between two SCSI target instances.
- Sits between the SCSI targets (IDs 0..1) and the host-side io controller.
- Serialises read and write requests with round-robin priority. Steers ack and buffer traffic to the granted target only.
- Reports which device index the host must service.

Parameters:
- TIMEOUT_W, 24, width of the optional watchdog counter. The transfer aborts when the counter reaches all-ones.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- t_lba0 / t_lba1  in  32  target 0/1 block address
- t_rd  in  2  per-target read request (level; bit n = target n)
- t_wr  in  2  per-target write request (level)
- t_ack  out  2  per-target ack; only the owner's bit can be high
- t_buff_din0 / t_buff_din1  in  8  target 0/1 buffer read data, used for writes to the host
- t_buff_wr  out  2  per-target buffer write strobe
- buff_addr  out  9  buffer address, broadcast to both targets
- buff_dout  out  8  buffer data, broadcast to both targets
- h_lba  out  32  latched LBA presented to the host
- h_dev  out  1  device index being serviced
- h_rd  out  1  host read request
- h_wr  out  1  host write request
- h_ack  in  1  host ack; high for the duration of the sector transfer
- h_buff_addr  in  9  host buffer address
- h_buff_dout  in  8  host buffer write data
- h_buff_wr  in  1  host buffer write strobe
- h_buff_din  out  8  host buffer read data, muxed from the owner
- busy  out  1  a transfer is in progress (state is not IDLE)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; h_rd=h_wr=0; t_ack=0; h_dev=0; h_lba=0; last_grant=1 (target 0 wins first); watchdog=0.
  - Reset mid-transfer drops h_rd/h_wr and t_ack on the next edge. No completion is signalled.
- Request vector: req[n] = t_rd[n] | t_wr[n].
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - If any req bit is set, grant using round-robin: prefer the target other than last_grant when both are requesting.
  - In the same cycle, latch h_dev=grant, h_lba=t_lba[grant], and op = t_wr[grant] (write if both rd and wr are set).
  - Update last_grant. Go to REQ.
- REQ:
  - h_rd = ~op, h_wr = op (registered; asserted the cycle after the grant).
  - When h_ack=1: deassert h_rd/h_wr and set t_ack[h_dev]=1 in the same edge. Go to XFER.
- XFER:
  - t_ack[h_dev] follows h_ack.
  - Buffer routing: t_buff_wr[h_dev] = h_buff_wr; buff_addr = h_buff_addr; buff_dout = h_buff_dout; h_buff_din = t_buff_din[h_dev].
  - These are combinational pass-throughs with zero latency. The non-owner's buff_wr bit is forced to 0.
  - On h_ack falling: t_ack=0, go to DONE.
- DONE: one cycle, then IDLE. This guarantees the owner sees its ack fall and can drop or re-raise its request before re-arbitration.
- Request ordering:
  - A request raised while another target owns the channel waits. No loss and no ack is given to it.
  - A requester that drops its request before its grant is simply skipped.
  - If the owner drops t_rd/t_wr during REQ, the arbiter still completes the host cycle. The host is never abandoned.
- Latency: request seen in IDLE to h_rd/h_wr high is 2 clk.
- Fairness: with both targets requesting continuously, grants alternate 0,1,0,1…
- Outside XFER: t_buff_wr=0; h_buff_din=0.
- h_lba and h_dev stay stable from grant until the state returns to IDLE.

Optional Feature:
- Macro SCSI_ARB_WATCHDOG_EN.
- When defined:
  - A TIMEOUT_W-bit counter clears on entry to REQ and increments each clk in REQ or XFER.
  - At all-ones: force h_rd=h_wr=0 and pulse t_ack[h_dev] high for 1 clk so the target unblocks and advances. Then go to DONE.
  - Sticky output timeout_flag (out, 1) is set; it clears only on reset.
- When undefined: the counter and the timeout_flag port do not exist, and the arbiter waits indefinitely for h_ack.

Test Plan:
- Single read: t_rd=2'b01, t_lba0=32'h1234 → h_rd=1 2 clk later, h_dev=0, h_lba=32'h1234. h_ack high 600 clk → t_ack=2'b01 for those cycles; host writes at h_buff_addr=5 data 8'hA5 → t_buff_wr=2'b01 with buff_dout=8'hA5.
- Contention: t_rd=2'b11 held → serviced order dev 0, 1, 0, 1. t_ack[1] never high while h_dev=0.
- Write path: t_wr=2'b10, t_buff_din1=8'h3C → h_wr=1, h_dev=1. During XFER h_buff_din=8'h3C; t_buff_wr stays 0.
- Late arrival: dev 1 requests while dev 0 is in XFER → dev 1 grant occurs only after DONE; h_lba stays t_lba0 until then.
- Reset mid-XFER: rst_n=0 for 1 clk → h_rd=h_wr=0, t_ack=0, busy=0 next cycle; a fresh request is granted to dev 0.
- Watchdog (SCSI_ARB_WATCHDOG_EN, TIMEOUT_W=4): t_rd=2'b01, h_ack held 0 → after 15 clk in REQ, h_rd drops, t_ack[0] pulses for 1 clk, timeout_flag=1.
